packet_scheduler: RTL and testbench

PACKET_SCHEDULER -- requirements
Module: packet_scheduler

---
 rtl/hdmi_packet_pkg.sv | 41 ++++
 rtl/audio_sample_fifo.sv | 74 +++++++
 rtl/packet_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_packet_scheduler.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_packet_pkg.sv
// Shared definitions for the HDMI data-island packet scheduler.
//   - HDMI packet type codes emitted on packet_type
//   - sched_state_t : scheduler state (which packet occupies the current slot)
//   - state_to_type : maps a scheduler state to its packet type code
// Optional feature macro: PACKET_SCHEDULER_SPD_EN adds the SPD InfoFrame state.
package hdmi_packet_pkg;

    localparam logic [7:0] PKT_NULL  = 8'h00;
    localparam logic [7:0] PKT_ACR   = 8'h01;
    localparam logic [7:0] PKT_AUDIO = 8'h02;
    localparam logic [7:0] PKT_AVI   = 8'h82;
    localparam logic [7:0] PKT_SPD   = 8'h83;
    localparam logic [7:0] PKT_AIF   = 8'h84;

    typedef enum logic [2:0] {
        ST_NULL,
        ST_ACR,
        ST_AVI,
        ST_AIF,
`ifdef PACKET_SCHEDULER_SPD_EN
        ST_SPD,
`endif
        ST_AUDIO
    } sched_state_t;

    function automatic logic [7:0] state_to_type(input sched_state_t s);
        logic [7:0] t;
        case (s)
            ST_ACR:   t = PKT_ACR;
            ST_AVI:   t = PKT_AVI;
            ST_AIF:   t = PKT_AIF;
`ifdef PACKET_SCHEDULER_SPD_EN
            ST_SPD:   t = PKT_SPD;
`endif
            ST_AUDIO: t = PKT_AUDIO;
            default:  t = PKT_NULL;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Audio sample-pair FIFO: single push, pops 0..4 entries per cycle.
// The four oldest entries are presented combinationally on peek_data
// (oldest in the lowest slot) so a consumer can latch them in the same
// cycle it pops them.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data when not full (or when a pop frees space)
//   push_data  : WIDTH-bit entry
//   pop_n      : number of entries to pop this cycle (caller keeps <= level)
//   peek_data  : four oldest entries, slot k at [k*WIDTH +: WIDTH]
//   level      : current occupancy, reaches DEPTH when full
//   overflow   : sticky, set when a push is dropped
module audio_sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic [2:0]               pop_n,
    output logic [4*WIDTH-1:0]       peek_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             r_overflow;
    logic             w_push_ok;

    // A pop in the same cycle frees space, so a push at full still lands.
    assign w_push_ok = push && ((r_level != LW'(DEPTH)) || (pop_n != 3'd0));

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            // Pointer width equals log2(DEPTH), so the add wraps modulo DEPTH.
            r_rd_ptr <= r_rd_ptr + AW'(pop_n);
            r_level  <= r_level + LW'(w_push_ok) - LW'(pop_n);
            if (push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        peek_data = '0;
        for (int k = 0; k < 4; k++) begin
            peek_data[k*WIDTH +: WIDTH] = r_mem[r_rd_ptr + AW'(k)];
        end
    end

    assign level    = r_level;
    assign overflow = r_overflow;

endmodule

// File: rtl/packet_scheduler.sv
// HDMI data-island packet scheduler. On every packet_enable slot it picks
// one packet: ACR once per frame, then the InfoFrame burst when due, then
// audio sample packets from the sample FIFO, otherwise a NULL packet.
// Ports:
//   clk_pixel, reset : pixel clock, asynchronous active-high reset
//   frame_start      : pulse at the first pixel of a frame
//   packet_enable    : pulse, a packet slot is available
//   sample_valid     : push strobe for sample_in ({right, left})
//   packet_type      : selected packet type, valid one cycle after packet_enable
//   audio_out        : up to four sample pairs, slot 0 oldest
//   sample_present   : mask of valid audio_out slots
//   fifo_level       : sample FIFO occupancy
//   overflow         : sticky, a sample was dropped at full FIFO
// Optional feature macro: PACKET_SCHEDULER_SPD_EN adds an SPD InfoFrame
// after the Audio InfoFrame in each burst.
//
// state    | meaning
// ---------+---------------------------------------------
// ST_NULL  | current slot carries a NULL packet
// ST_ACR   | current slot carries Audio Clock Regeneration
// ST_AVI   | current slot carries the AVI InfoFrame
// ST_AIF   | current slot carries the Audio InfoFrame
// ST_SPD   | current slot carries the SPD InfoFrame (SPD builds only)
// ST_AUDIO | current slot carries an audio sample packet
module packet_scheduler
    import hdmi_packet_pkg::*;
#(
    parameter int AUDIO_BIT_WIDTH        = 16,
    parameter int FIFO_DEPTH             = 16,
    parameter int MAX_SAMPLES_PER_PACKET = 4,
    parameter int INFOFRAME_PERIOD       = 1
) (
    input  logic                           clk_pixel,
    input  logic                           reset,
    input  logic                           frame_start,
    input  logic                           packet_enable,
    input  logic                           sample_valid,
    input  logic [2*AUDIO_BIT_WIDTH-1:0]   sample_in,
    output logic [7:0]                     packet_type,
    output logic [4*2*AUDIO_BIT_WIDTH-1:0] audio_out,
    output logic [3:0]                     sample_present,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
    output logic                           overflow
);
    localparam int PW  = 2 * AUDIO_BIT_WIDTH;
    localparam int LW  = $clog2(FIFO_DEPTH) + 1;
    localparam int FCW = (INFOFRAME_PERIOD > 1) ? $clog2(INFOFRAME_PERIOD) : 1;

    sched_state_t    r_state;
    sched_state_t    w_state_next;
    logic            r_acr_sent;
    logic            r_avi_due;
    logic            r_aif_due;
    logic [FCW-1:0]  r_frame_cnt;
    logic [7:0]      r_packet_type;
    logic [4*PW-1:0] r_audio_out;
    logic [3:0]      r_sample_present;

    logic            w_burst_arm;
    logic            w_acr_sent;
    logic            w_avi_due;
    logic            w_aif_due;
    logic [LW-1:0]   w_level;
    logic [4*PW-1:0] w_peek;
    logic [2:0]      w_avail_n;
    logic [2:0]      w_pop_n;
    logic [4*PW-1:0] w_slot_data;
    logic [3:0]      w_slot_mask;
    logic            w_fifo_overflow;

`ifdef PACKET_SCHEDULER_SPD_EN
    logic            r_spd_due;
    logic            w_spd_due;
`endif

    // The frame that starts while the counter sits at zero gets a burst, so
    // the first frame after reset and every INFOFRAME_PERIOD-th one after it
    // carry InfoFrames.
    assign w_burst_arm = frame_start && (r_frame_cnt == '0);

    // frame_start takes effect before a coincident packet_enable is decoded.
    assign w_acr_sent = r_acr_sent && !frame_start;
    assign w_avi_due  = r_avi_due || w_burst_arm;
    assign w_aif_due  = r_aif_due || w_burst_arm;
`ifdef PACKET_SCHEDULER_SPD_EN
    assign w_spd_due  = r_spd_due || w_burst_arm;
`endif

    assign w_avail_n = (w_level >= LW'(MAX_SAMPLES_PER_PACKET)) ?
                       3'(MAX_SAMPLES_PER_PACKET) : 3'(w_level);

    always_comb begin
        w_state_next = r_state;
        if (packet_enable) begin
            if (!w_acr_sent) begin
                w_state_next = ST_ACR;
            end else if (w_avi_due) begin
                w_state_next = ST_AVI;
            end else if (w_aif_due) begin
                w_state_next = ST_AIF;
`ifdef PACKET_SCHEDULER_SPD_EN
            end else if (w_spd_due) begin
                w_state_next = ST_SPD;
`endif
            end else if (w_level != '0) begin
                w_state_next = ST_AUDIO;
            end else begin
                w_state_next = ST_NULL;
            end
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            r_state <= ST_NULL;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_pop_n = (packet_enable && (w_state_next == ST_AUDIO)) ? w_avail_n : 3'd0;

    always_comb begin
        w_slot_data = '0;
        w_slot_mask = '0;
        if (w_state_next == ST_AUDIO) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < w_avail_n) begin
                    w_slot_data[k*PW +: PW] = w_peek[k*PW +: PW];
                    w_slot_mask[k]          = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            r_acr_sent  <= 1'b0;
            r_avi_due   <= 1'b1;
            r_aif_due   <= 1'b1;
`ifdef PACKET_SCHEDULER_SPD_EN
            r_spd_due   <= 1'b1;
`endif
            r_frame_cnt <= '0;
        end else begin
            if (frame_start) begin
                r_frame_cnt <= (r_frame_cnt == FCW'(INFOFRAME_PERIOD - 1)) ?
                               '0 : r_frame_cnt + 1'b1;
            end
            r_acr_sent <= w_acr_sent || (packet_enable && (w_state_next == ST_ACR));
            r_avi_due  <= w_avi_due && !(packet_enable && (w_state_next == ST_AVI));
            r_aif_due  <= w_aif_due && !(packet_enable && (w_state_next == ST_AIF));
`ifdef PACKET_SCHEDULER_SPD_EN
            r_spd_due  <= w_spd_due && !(packet_enable && (w_state_next == ST_SPD));
`endif
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            r_packet_type    <= PKT_NULL;
            r_audio_out      <= '0;
            r_sample_present <= '0;
        end else if (packet_enable) begin
            r_packet_type    <= state_to_type(w_state_next);
            r_audio_out      <= w_slot_data;
            r_sample_present <= w_slot_mask;
        end
    end

    audio_sample_fifo #(
        .WIDTH (PW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_pixel),
        .rst       (reset),
        .push      (sample_valid),
        .push_data (sample_in),
        .pop_n     (w_pop_n),
        .peek_data (w_peek),
        .level     (w_level),
        .overflow  (w_fifo_overflow)
    );

    assign packet_type    = r_packet_type;
    assign audio_out      = r_audio_out;
    assign sample_present = r_sample_present;
    assign fifo_level     = w_level;
    assign overflow       = w_fifo_overflow;

endmodule

// File: tb/tb_packet_scheduler.sv
// Bench for packet_scheduler: directed scenarios with literal expectations
// followed by randomized traffic, all compared every cycle against a
// queue-based reference model.
module tb_packet_scheduler;
    localparam int W     = 16;
    localparam int DEPTH = 16;
    localparam int MAXS  = 4;
    localparam int IP    = 2;
    localparam int PW    = 2 * W;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic            clk_pixel = 1'b0;
    logic            reset = 1'b1;
    logic            frame_start = 1'b0;
    logic            packet_enable = 1'b0;
    logic            sample_valid = 1'b0;
    logic [PW-1:0]   sample_in = '0;
    logic [7:0]      packet_type;
    logic [4*PW-1:0] audio_out;
    logic [3:0]      sample_present;
    logic [LW-1:0]   fifo_level;
    logic            overflow;

    packet_scheduler #(
        .AUDIO_BIT_WIDTH        (W),
        .FIFO_DEPTH             (DEPTH),
        .MAX_SAMPLES_PER_PACKET (MAXS),
        .INFOFRAME_PERIOD       (IP)
    ) dut (
        .clk_pixel      (clk_pixel),
        .reset          (reset),
        .frame_start    (frame_start),
        .packet_enable  (packet_enable),
        .sample_valid   (sample_valid),
        .sample_in      (sample_in),
        .packet_type    (packet_type),
        .audio_out      (audio_out),
        .sample_present (sample_present),
        .fifo_level     (fifo_level),
        .overflow       (overflow)
    );

    always #5 clk_pixel = ~clk_pixel;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [PW-1:0]   m_q[$];
    logic [7:0]      m_pending[$];
    int              m_frame;
    bit              m_acr;
    logic [7:0]      e_type;
    logic [4*PW-1:0] e_audio;
    logic [3:0]      e_sp;
    bit              e_ovf;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic arm_burst();
        m_pending.delete();
        m_pending.push_back(8'h82);
        m_pending.push_back(8'h84);
`ifdef PACKET_SCHEDULER_SPD_EN
        m_pending.push_back(8'h83);
`endif
    endtask

    task automatic model_reset();
        m_q.delete();
        arm_burst();
        m_frame = 0;
        m_acr   = 1'b0;
        e_type  = 8'h00;
        e_audio = '0;
        e_sp    = '0;
        e_ovf   = 1'b0;
    endtask

    task automatic model_clock(input bit fs, input bit pe, input bit sv, input logic [PW-1:0] d);
        int lvl;
        int n;
        lvl = m_q.size();
        n   = 0;
        if (fs) begin
            m_acr = 1'b0;
            if (m_frame % IP == 0) arm_burst();
            m_frame++;
        end
        if (pe) begin
            e_audio = '0;
            e_sp    = '0;
            if (!m_acr) begin
                e_type = 8'h01;
                m_acr  = 1'b1;
            end else if (m_pending.size() > 0) begin
                e_type = m_pending.pop_front();
            end else if (lvl > 0) begin
                e_type = 8'h02;
                n = (lvl < MAXS) ? lvl : MAXS;
                for (int k = 0; k < n; k++) begin
                    e_audio[k*PW +: PW] = m_q.pop_front();
                    e_sp[k] = 1'b1;
                end
            end else begin
                e_type = 8'h00;
            end
        end
        if (sv) begin
            if (lvl - n < DEPTH) m_q.push_back(d);
            else e_ovf = 1'b1;
        end
    endtask

    task automatic compare_all();
        check("packet_type", {120'd0, packet_type}, {120'd0, e_type});
        check("audio_out", audio_out, e_audio);
        check("sample_present", {124'd0, sample_present}, {124'd0, e_sp});
        check("fifo_level", {{(128-LW){1'b0}}, fifo_level}, 128'(m_q.size()));
        check("overflow", {127'd0, overflow}, {127'd0, e_ovf});
    endtask

    task automatic cycle(input bit fs, input bit pe, input bit sv, input logic [PW-1:0] d);
        frame_start   = fs;
        packet_enable = pe;
        sample_valid  = sv;
        sample_in     = d;
        @(posedge clk_pixel);
        model_clock(fs, pe, sv, d);
        #1;
        frame_start   = 1'b0;
        packet_enable = 1'b0;
        sample_valid  = 1'b0;
        compare_all();
    endtask

    task automatic pe_expect(input string nm, input logic [7:0] t);
        cycle(1'b0, 1'b1, 1'b0, '0);
        check(nm, {120'd0, packet_type}, {120'd0, t});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("rst_async_type", {120'd0, packet_type}, 128'h0);
        check("rst_async_sp", {124'd0, sample_present}, 128'h0);
        @(posedge clk_pixel);
        #1;
        reset = 1'b0;
        compare_all();
    endtask

    initial begin
        logic [PW-1:0] d;
        model_reset();
        #12;
        compare_all();
        check("rst_level", {{(128-LW){1'b0}}, fifo_level}, 128'h0);
        check("rst_ovf", {127'd0, overflow}, 128'h0);
        reset = 1'b0;

        // Frame 0: burst due, FIFO empty
        cycle(1'b1, 1'b0, 1'b0, '0);
        pe_expect("f0_s0", 8'h01);
        pe_expect("f0_s1", 8'h82);
        pe_expect("f0_s2", 8'h84);
`ifdef PACKET_SCHEDULER_SPD_EN
        pe_expect("f0_s3", 8'h83);
`else
        pe_expect("f0_s3", 8'h00);
`endif
        // Frame 1: no burst with period 2
        cycle(1'b1, 1'b0, 1'b0, '0);
        pe_expect("f1_s0", 8'h01);
        pe_expect("f1_s1", 8'h00);
        pe_expect("f1_s2", 8'h00);
        // Frame 2: burst again
        cycle(1'b1, 1'b0, 1'b0, '0);
        pe_expect("f2_s0", 8'h01);
        pe_expect("f2_s1", 8'h82);
        pe_expect("f2_s2", 8'h84);
`ifdef PACKET_SCHEDULER_SPD_EN
        pe_expect("f2_s3", 8'h83);
`endif

        // Six pairs -> 4 then 2
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1, {16'(16'hB0 + i), 16'(16'hA0 + i)});
        check("push6_level", {{(128-LW){1'b0}}, fifo_level}, 128'd6);
        pe_expect("aud1_type", 8'h02);
        check("aud1_sp", {124'd0, sample_present}, 128'hF);
        check("aud1_slot0", {96'd0, audio_out[PW-1:0]}, 128'h00B0_00A0);
        check("aud1_level", {{(128-LW){1'b0}}, fifo_level}, 128'd2);
        pe_expect("aud2_type", 8'h02);
        check("aud2_sp", {124'd0, sample_present}, 128'h3);
        check("aud2_data", audio_out, 128'h0000_0000_0000_0000_00B5_00A5_00B4_00A4);
        check("aud2_level", {{(128-LW){1'b0}}, fifo_level}, 128'd0);
        pe_expect("aud3_null", 8'h00);

        // Fill to full, overflow, push coincident with pop at full
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b0, 1'b1, 32'h1000_0000 + 32'(i));
        check("full_level", {{(128-LW){1'b0}}, fifo_level}, 128'd16);
        check("full_ovf", {127'd0, overflow}, 128'h0);
        cycle(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        check("ovf_level", {{(128-LW){1'b0}}, fifo_level}, 128'd16);
        check("ovf_flag", {127'd0, overflow}, 128'h1);
        cycle(1'b0, 1'b1, 1'b1, 32'hCAFE_F00D);
        check("pushpop_level", {{(128-LW){1'b0}}, fifo_level}, 128'd13);
        pe_expect("drain1", 8'h02);
        pe_expect("drain2", 8'h02);
        pe_expect("drain3", 8'h02);
        check("drain3_slot3", {96'd0, audio_out[3*PW +: PW]}, 128'h1000_000F);
        pe_expect("drain4", 8'h02);
        check("drain4_sp", {124'd0, sample_present}, 128'h1);
        check("drain4_slot0", {96'd0, audio_out[PW-1:0]}, 128'hCAFE_F00D);
        check("ovf_sticky", {127'd0, overflow}, 128'h1);

        // frame_start with packet_enable mid-audio, then reset during audio
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1, 32'h2000_0000 + 32'(i));
        pe_expect("mid_aud", 8'h02);
        cycle(1'b1, 1'b1, 1'b0, '0);
        check("fs_pe_acr", {120'd0, packet_type}, 128'h01);
        pe_expect("f3_aud", 8'h02);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 32'h3000_0000 + 32'(i));
        pe_expect("pre_rst_aud", 8'h02);
        do_reset();
        check("post_rst_level", {{(128-LW){1'b0}}, fifo_level}, 128'd0);
        check("post_rst_ovf", {127'd0, overflow}, 128'h0);
        pe_expect("post_rst_acr", 8'h01);

        // Randomized traffic: moderate then heavy push load
        for (int i = 0; i < 4000; i++) begin
            d = PW'($urandom);
            if (i < 2000)
                cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 2) == 0, d);
            else
                cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 9) != 0, d);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

`ifndef PACKET_SCHEDULER_SPD_EN
    // The SPD code must never appear in a default build.
    always @(negedge clk_pixel) begin
        if (!reset && packet_type == 8'h83) begin
            n_checks++;
            n_errors++;
            $display("FAIL no_spd: got %h expected not 83", packet_type);
        end
    end
`endif

endmodule
